// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: req/ack access bus between one master and the arbiter
interface mem_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
    logic          req;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    logic          ack;
    modport master(output req, we, adr, wd, input rd, ack);
    modport slave(input req, we, adr, wd, output rd, ack);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-master arbiter for a single mem, fixed 3-cycle IDLE/ACCESS/RESP access
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t        state, state_n;
    logic          owner, owner_n, last;
    logic [DW-1:0] rd_q;
    logic          any, acc, resp;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            rd_q  <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            if (acc) begin
                last <= owner;
                rd_q <= mem_rd;
            end
        end
    // a tie goes to whichever master was not granted last
    always_comb begin
        any     = m0.req | m1.req;
        acc     = state == ACCESS;
        resp    = state == RESP;
        state_n = state == IDLE ? (any ? ACCESS : IDLE) : acc ? RESP : IDLE;
        owner_n = (state == IDLE && any) ? ((m0.req && m1.req) ? !last : m1.req) : owner;
        mem_we  = acc ? (owner ? m1.we : m0.we) : 1'b0;
        mem_a   = acc ? (owner ? m1.adr : m0.adr) : '0;
        mem_wd  = acc ? (owner ? m1.wd : m0.wd) : '0;
        m0.ack  = resp && !owner;
        m1.ack  = resp && owner;
        m0.rd   = m0.ack ? rd_q : '0;
        m1.rd   = m1.ack ? rd_q : '0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized two-master traffic against a transaction-level model
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
    mem_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd, mem_rd;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    logic        req[2], we[2], ack[2];
    logic [31:0] adr[2], wd[2], rd[2];
    assign m0_if.req = req[0];
    assign m0_if.we  = we[0];
    assign m0_if.adr = adr[0];
    assign m0_if.wd  = wd[0];
    assign m1_if.req = req[1];
    assign m1_if.we  = we[1];
    assign m1_if.adr = adr[1];
    assign m1_if.wd  = wd[1];
    assign ack[0] = m0_if.ack;
    assign ack[1] = m1_if.ack;
    assign rd[0]  = m0_if.rd;
    assign rd[1]  = m1_if.rd;

    logic [31:0] tbmem [256];
    logic [31:0] refmem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = 8'd0;
    logic [31:0] pl_dat = 32'd0;
    assign mem_rd = tbmem[mem_a[9:2]];
    always @(posedge clk)
        if (pl_en) tbmem[pl_idx] <= pl_dat;
        else if (mem_we) tbmem[mem_a[9:2]] <= mem_wd;

    int checks = 0;
    int errors = 0;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int idx, input logic [31:0] v);
        pl_en = 1'b1;
        pl_idx = 8'(idx);
        pl_dat = v;
        refmem[idx] = v;
        step();
        pl_en = 1'b0;
    endtask

    task automatic idle_all;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; adr[i] = 32'd0; wd[i] = 32'd0;
        end
    endtask

    task automatic do_reset;
        idle_all();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset;
        idle_all();
        req[0] = 1'b1; req[1] = 1'b1; we[0] = 1'b1; we[1] = 1'b1;
        adr[0] = 32'h44; adr[1] = 32'h88; wd[0] = 32'h1; wd[1] = 32'h2;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({mem_we, mem_a, mem_wd, ack[0], ack[1], rd[0], rd[1]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs c=%0d got we=%b a=%h wd=%h ack=%b%b exp all 0", c, mem_we, mem_a, mem_wd, ack[0], ack[1]);
            end
        end
        do_reset();
    endtask

    task automatic test_idle;
        idle_all();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({mem_we, mem_a, mem_wd, ack[0], ack[1], rd[0], rd[1]} !== '0) begin
                errors++;
                $display("FAIL idle_outputs c=%0d got we=%b a=%h wd=%h ack=%b%b rd=%h/%h exp all 0", c, mem_we, mem_a, mem_wd, ack[0], ack[1], rd[0], rd[1]);
            end
            step();
        end
    endtask

    task automatic test_single_read;
        poke(16, 32'hDEADBEEF);
        req[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h40;
        step();
        @(negedge clk);
        checks++;
        if (mem_a !== 32'h40 || mem_we !== 1'b0 || ack[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_access a=%h we=%b ack0=%b exp a=00000040 we=0 ack0=0", mem_a, mem_we, ack[0]);
        end
        step();
        @(negedge clk);
        checks++;
        if (ack[0] !== 1'b1 || rd[0] !== 32'hDEADBEEF || ack[1] !== 1'b0) begin
            errors++;
            $display("FAIL single_ack ack0=%b rd0=%h ack1=%b exp 1 deadbeef 0", ack[0], rd[0], ack[1]);
        end
        step();
        req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (ack[0] !== 1'b0 || rd[0] !== 32'd0) begin
            errors++;
            $display("FAIL single_after ack0=%b rd0=%h exp 0 0", ack[0], rd[0]);
        end
        step();
    endtask

    task automatic test_write_readback;
        int wes;
        wes = 0;
        req[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h80; wd[1] = 32'h12345678;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            wes += int'(mem_we);
            if (c == 2) begin
                checks++;
                if (ack[1] !== 1'b1 || ack[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL wr_ack ack1=%b ack0=%b exp 1 0", ack[1], ack[0]);
                end
            end
            step();
        end
        checks++;
        if (wes != 1) begin
            errors++;
            $display("FAIL wr_we_cycles got %0d exp 1", wes);
        end
        refmem[32] = 32'h12345678;
        we[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (ack[1] !== 1'b1 || rd[1] !== 32'h12345678) begin
                    errors++;
                    $display("FAIL rd_back ack1=%b rd1=%h exp 1 12345678", ack[1], rd[1]);
                end
            end
            step();
        end
        idle_all();
        step();
    endtask

    task automatic test_contention;
        poke(1, 32'h11110001);
        poke(2, 32'h22220002);
        do_reset();
        req[0] = 1'b1; adr[0] = 32'h4;
        req[1] = 1'b1; adr[1] = 32'h8;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (ack[0] !== (c == 2 || c == 8) || ack[1] !== (c == 5 || c == 11)) begin
                errors++;
                $display("FAIL contend_order c=%0d ack=%b%b exp %b%b", c, ack[0], ack[1], c == 2 || c == 8, c == 5 || c == 11);
            end
            if (c == 2 || c == 5) begin
                checks++;
                if ((c == 2 ? rd[0] : rd[1]) !== (c == 2 ? 32'h11110001 : 32'h22220002)) begin
                    errors++;
                    $display("FAIL contend_rd c=%0d got %h/%h", c, rd[0], rd[1]);
                end
            end
            step();
        end
        idle_all();
        step();
    endtask

    task automatic test_solo_stream;
        do_reset();
        req[1] = 1'b1; adr[1] = 32'h4;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (ack[1] !== (c % 3 == 2) || ack[0] !== 1'b0 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL solo_stream c=%0d ack1=%b ack0=%b we=%b exp %b 0 0", c, ack[1], ack[0], mem_we, c % 3 == 2);
            end
            step();
        end
        idle_all();
        step();
    endtask

    task automatic test_reset_in_access;
        do_reset();
        poke(4, 32'h0BADF00D);
        req[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h10; wd[0] = 32'hAAAA5555;
        step();
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_wd !== 32'hAAAA5555) begin
            errors++;
            $display("FAIL rst_acc_pre we=%b wd=%h exp 1 aaaa5555", mem_we, mem_wd);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || mem_a !== 32'd0 || ack[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_acc_drop we=%b a=%h ack0=%b exp 0 0 0", mem_we, mem_a, ack[0]);
        end
        step();
        req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (tbmem[4] !== refmem[4] || ack[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_acc_mem mem=%h ack0=%b exp %h 0", tbmem[4], ack[0], refmem[4]);
        end
        reset = 1'b0;
        step();
        req[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h10;
        req[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h8;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (ack[0] !== (c == 2) || ack[1] !== (c == 5) || (c == 2 && rd[0] !== refmem[4])) begin
                errors++;
                $display("FAIL rst_tie c=%0d ack=%b%b rd0=%h exp %b%b", c, ack[0], ack[1], rd[0], c == 2, c == 5);
            end
            step();
        end
        idle_all();
        step();
    endtask

    task automatic test_random;
        int ack_at[2], next_free, acc_at, g;
        logic last_g, acc_we, gen, rd_chk[2];
        logic [31:0] acc_adr, acc_wd, rd_exp[2], ea, ew;
        do_reset();
        for (int k = 0; k < 256; k++) poke(k, $urandom);
        ack_at[0] = -1; ack_at[1] = -1; acc_at = -1; next_free = 0; last_g = 1'b1;
        rd_chk[0] = 1'b0; rd_chk[1] = 1'b0; rd_exp[0] = 0; rd_exp[1] = 0;
        acc_we = 1'b0; acc_adr = 0; acc_wd = 0;
        for (int n = 0; n < 600; n++) begin
            gen = n < 500;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (ack[i] !== (ack_at[i] == n) || (ack_at[i] != n && rd[i] !== 32'd0) ||
                    (ack_at[i] == n && rd_chk[i] && rd[i] !== rd_exp[i])) begin
                    errors++;
                    $display("FAIL rnd_resp m%0d n=%0d ack=%b rd=%h exp ack=%b rd=%h", i, n, ack[i], rd[i], ack_at[i] == n, rd_exp[i]);
                end
            end
            ea = acc_at == n ? acc_adr : 32'd0;
            ew = acc_at == n ? acc_wd : 32'd0;
            checks++;
            if (mem_we !== (acc_at == n && acc_we) || mem_a !== ea || mem_wd !== ew) begin
                errors++;
                $display("FAIL rnd_mem n=%0d we=%b a=%h wd=%h exp %b %h %h", n, mem_we, mem_a, mem_wd, acc_at == n && acc_we, ea, ew);
            end
            if (n >= next_free && (req[0] || req[1])) begin
                g = (req[0] && req[1]) ? int'(!last_g) : int'(req[1]);
                last_g = g[0];
                acc_at = n + 1;
                ack_at[g] = n + 2;
                next_free = n + 3;
                acc_we = we[g]; acc_adr = adr[g]; acc_wd = wd[g];
                rd_chk[g] = !we[g];
                rd_exp[g] = refmem[adr[g][9:2]];
                if (we[g]) refmem[adr[g][9:2]] = wd[g];
            end
            step();
            for (int i = 0; i < 2; i++) begin
                if (req[i] ? ack_at[i] == n : 1'b1) begin
                    req[i] = gen && ($urandom_range(2, 0) == 0 || (req[i] && $urandom_range(1, 0) == 1));
                    we[i] = 1'($urandom_range(1, 0));
                    adr[i] = 32'($urandom_range(15, 0)) << 2;
                    wd[i] = $urandom;
                end
            end
        end
        idle_all();
        step();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_idle();
        test_single_read();
        test_write_readback();
        test_contention();
        test_solo_stream();
        test_reset_in_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single unified `mem` instance between the `arm` core (master 0) and a second bus master such as a loader or DMA engine (master 1). It sits between both masters and `mem`, and drives `mem`'s `we`/`a`/`wd` while sampling its combinational `rd`. Requests use a req/ack handshake. Contention is resolved round-robin, and each access completes in a fixed three-cycle sequence.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `m0_req`  in  1  master 0 request; held until `m0_ack`
- `m0_we`  in  1  master 0 write enable; 1 = write, 0 = read
- `m0_adr`  in  AW  master 0 byte address
- `m0_wd`  in  DW  master 0 write data
- `m0_rd`  out  DW  master 0 read data; valid while `m0_ack`=1
- `m0_ack`  out  1  master 0 one-cycle completion pulse
- `m1_req`, `m1_we`, `m1_adr`, `m1_wd`, `m1_rd`, `m1_ack`: same as master 0, for master 1
- `mem_we`  out  1  write enable to `mem`
- `mem_a`  out  AW  address to `mem`
- `mem_wd`  out  DW  write data to `mem`
- `mem_rd`  in  DW  combinational read data from `mem`

## Operation
- FSM states: IDLE, ACCESS, RESP. Registers: `owner` (1 bit), `last` (1 bit, last master granted), `rd_q` (DW bits).
- IDLE:
  - No req: stay in IDLE.
  - One req: `owner` = that master; go to ACCESS.
  - Both req: `owner` = `!last`; go to ACCESS.
- ACCESS:
  - `mem_a`, `mem_wd` and `mem_we` come from the owner's `adr`/`wd`/`we`.
  - Write commits to `mem` at the rising edge that ends ACCESS.
  - At the same edge, `rd_q` ← `mem_rd` on a read. On a write, `rd_q` is loaded too, but its value is don't-care.
  - `last` ← `owner`; go to RESP.
- RESP:
  - Owner's `ack` = 1 and owner's `rd` = `rd_q`.
  - Always go to IDLE. All req inputs are ignored in this state.
- Outside ACCESS: `mem_we`=0, `mem_a`=0, `mem_wd`=0.
- Non-owner `ack`=0 at all times. `mX_rd` = `rd_q` when `mX_ack`=1, else 0.
- Master rule: keep req/we/adr/wd stable from req assertion through the ack cycle. Deassert req, or present a new request, in the cycle after ack. Behaviour is undefined if inputs change earlier.
- A master holding req continuously gets one access per 3 cycles when uncontended. Under contention, grants strictly alternate, so the worst-case wait is one foreign access (3 cycles) plus its own.
- Reset (any time): state=IDLE, `owner`=0, `last`=1 (master 0 wins the first tie), `rd_q`=0. All outputs go to 0 immediately.
  - Asserted during ACCESS before the edge: the write is suppressed and no ack is issued. The master must re-request.
  - Asserted during RESP: the ack is dropped.

## Timing
- Request seen at edge E0 (state IDLE) → ACCESS in cycle after E0 → write/capture at E1 → ack high for exactly the cycle between E1 and E2.
- Latency from the first cycle req is high to ack = 2 cycles when uncontended. Throughput is 1 access per 3 cycles.
- `mem_*` outputs are decoded combinationally from state and `owner`, with no glitch-dependent behaviour. `mem_we` is high only in ACCESS.
- `ack` and `rd` are decoded from registered state, so they are stable for the whole RESP cycle.
- Simultaneous req from a master arriving during ACCESS/RESP is simply held and arbitrated in the next IDLE.

## Test plan
- Single read: mem[0x40]=0xDEADBEEF; `m0_req`=1, `m0_we`=0, `m0_adr`=0x40 → `mem_a`=0x40 in cycle 1, `mem_we`=0; `m0_ack`=1 with `m0_rd`=0xDEADBEEF in cycle 2; `m1_ack` stays 0.
- Write then read back: m1 writes 0x12345678 to 0x80 (`mem_we`=1 exactly one cycle), then m1 reads 0x80 → `m1_rd`=0x12345678 on ack.
- Contention after reset: m0 and m1 both request in the same cycle → m0 acked first (cycle 2), m1 acked at cycle 5. With both held continuously, the ack order is m0, m1, m0, m1 at 3-cycle spacing.
- Solo streaming: `m1_req` held high, m0 idle → `m1_ack` pulses every 3rd cycle; `mem_we` never asserts for m0.
- Reset in ACCESS: m0 write 0xAAAA5555 to 0x10, reset asserted mid-ACCESS cycle → `mem_we` drops to 0 immediately, mem[0x10] unchanged, no ack, state IDLE. After release, the first tie goes to m0.
- Idle outputs: no requests for 10 cycles → `mem_we`/`mem_a`/`mem_wd`/acks/rd all 0 throughout.
